// File: rtl/aabb_hit_pipe.sv
// Purpose: pipelined multi-lane ray/AABB slab test, reduced to the closest or first-hitting lane.
// Latency: 4 cycles from acceptance to out_valid, one ray per clock.
// Backpressure: global stall; in_ready = !out_valid || out_ready, so the output holds while out_ready is low.
module aabb_hit_pipe #(
  parameter int FIXED_WIDTH = 32,
  parameter int FRAC_BITS   = 16,
  parameter int NUM_LANES   = 4,
  parameter int PI_WIDTH    = 16,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic                                 mode_any,
  input  logic [3*FIXED_WIDTH-1:0]             ray_orig,
  input  logic [3*FIXED_WIDTH-1:0]             ray_invdir,
  input  logic [2:0]                           ray_dir_sign,
  input  logic [2:0]                           ray_dir_zero,
  input  logic [FIXED_WIDTH-1:0]               ray_min_t,
  input  logic [FIXED_WIDTH-1:0]               ray_max_t,
  input  logic [PI_WIDTH-1:0]                  ray_pi,
  input  logic [NUM_LANES*3*FIXED_WIDTH-1:0]   aabb_min,
  input  logic [NUM_LANES*3*FIXED_WIDTH-1:0]   aabb_max,
  input  logic [NUM_LANES*PI_WIDTH-1:0]        lane_pi,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic                                 out_hit,
  output logic [FIXED_WIDTH-1:0]               out_t,
  output logic [PI_WIDTH-1:0]                  out_pi,
  output logic [$clog2(NUM_LANES):0]           out_lane,
  output logic [5:0]                           out_normal,
  input  logic                                 stat_clear,
  output logic [CNT_WIDTH-1:0]                 hit_count
);

  localparam int FW = FIXED_WIDTH;
  localparam int NL = NUM_LANES;
  localparam int LW = $clog2(NUM_LANES) + 1;

  localparam logic [FW-1:0] T_POS     = {1'b0, {(FW-1){1'b1}}};          // +MAX
  localparam logic [FW-1:0] T_NEG     = {1'b1, {(FW-2){1'b0}}, 1'b1};    // -MAX
  localparam logic [FW-1:0] T_SAT_NEG = {1'b1, {(FW-1){1'b0}}};          // most negative

  // Per-ray fields that ride alongside the lane data through every stage.
  typedef struct packed {
    logic                       mode_any;
    logic [2:0]                 sign;
    logic [2:0]                 zero;
    logic [FW-1:0]              min_t;
    logic [FW-1:0]              max_t;
    logic [PI_WIDTH-1:0]        ray_pi;
    logic [NL*PI_WIDTH-1:0]     lane_pi;
  } meta_t;

  function automatic logic slt(input logic [FW-1:0] a, input logic [FW-1:0] b);
    return $signed(a) < $signed(b);
  endfunction

  function automatic logic sle(input logic [FW-1:0] a, input logic [FW-1:0] b);
    return $signed(a) <= $signed(b);
  endfunction

  function automatic logic [FW-1:0] smin(input logic [FW-1:0] a, input logic [FW-1:0] b);
    return slt(a, b) ? a : b;
  endfunction

  function automatic logic [FW-1:0] smax(input logic [FW-1:0] a, input logic [FW-1:0] b);
    return slt(a, b) ? b : a;
  endfunction

  function automatic logic is_pos(input logic [FW-1:0] a);
    return !a[FW-1] && (a != '0);
  endfunction

  // Fixed-point multiply of a (FW+1)-bit difference by 1/dir, rescaled and saturated to FW bits.
  function automatic logic [FW-1:0] mul_sat(input logic [FW:0] d, input logic [FW-1:0] inv);
    logic signed [2*FW:0] de;
    logic signed [2*FW:0] ie;
    logic signed [2*FW:0] p;
    de = $signed({{FW{d[FW]}}, d});
    ie = $signed({{(FW+1){inv[FW-1]}}, inv});
    p  = (de * ie) >>> FRAC_BITS;
    if ((&p[2*FW:FW-1]) || !(|p[2*FW:FW-1])) return p[FW-1:0];
    else if (p[2*FW])                        return T_SAT_NEG;
    else                                     return T_POS;
  endfunction

  logic  adv;
  meta_t in_meta;

  assign in_ready = !out_valid || out_ready;
  assign adv      = in_ready;
  assign in_meta  = {mode_any, ray_dir_sign, ray_dir_zero, ray_min_t, ray_max_t, ray_pi, lane_pi};

  logic          s1_vld;
  meta_t         s1_meta;
  logic [FW:0]   s1_d0 [NL][3];
  logic [FW:0]   s1_d1 [NL][3];
  logic [FW-1:0] s1_inv [3];

  // S1: slab-plane offsets from the origin, one extra bit so the difference never wraps.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_vld <= 1'b0;
    end else if (adv) begin
      s1_vld  <= in_valid;
      s1_meta <= in_meta;
      for (int a = 0; a < 3; a++) begin
        s1_inv[a] <= ray_invdir[a*FW +: FW];
        for (int l = 0; l < NL; l++) begin
          s1_d0[l][a] <= {aabb_min[(l*3+a)*FW + FW-1], aabb_min[(l*3+a)*FW +: FW]}
                       - {ray_orig[a*FW + FW-1], ray_orig[a*FW +: FW]};
          s1_d1[l][a] <= {aabb_max[(l*3+a)*FW + FW-1], aabb_max[(l*3+a)*FW +: FW]}
                       - {ray_orig[a*FW + FW-1], ray_orig[a*FW +: FW]};
        end
      end
    end
  end

  logic          s2_vld;
  meta_t         s2_meta;
  logic [FW-1:0] s2_t0 [NL][3];
  logic [FW-1:0] s2_t1 [NL][3];

  // S2: plane-crossing distances; a zero-direction axis becomes an all/nothing slab.
  always_ff @(posedge clk) begin
    if (reset) begin
      s2_vld <= 1'b0;
    end else if (adv) begin
      s2_vld  <= s1_vld;
      s2_meta <= s1_meta;
      for (int l = 0; l < NL; l++) begin
        for (int a = 0; a < 3; a++) begin
          if (s1_meta.zero[a]) begin
            if ((s1_d0[l][a][FW] || (s1_d0[l][a] == '0)) && !s1_d1[l][a][FW]) begin
              s2_t0[l][a] <= T_NEG;
              s2_t1[l][a] <= T_POS;
            end else begin
              s2_t0[l][a] <= T_POS;
              s2_t1[l][a] <= T_NEG;
            end
          end else begin
            s2_t0[l][a] <= mul_sat(s1_d0[l][a], s1_inv[a]);
            s2_t1[l][a] <= mul_sat(s1_d1[l][a], s1_inv[a]);
          end
        end
      end
    end
  end

  logic [FW-1:0] c_min [NL];
  logic [FW-1:0] c_max [NL];

  // S3 combinational: intersect the three slabs. Zero-direction axes pass through unsorted
  // so an origin outside that slab yields an empty interval (+MAX..-MAX) and a certain miss.
  always_comb begin
    logic [FW-1:0] lo;
    logic [FW-1:0] hi;
    lo = '0;
    hi = '0;
    for (int l = 0; l < NL; l++) begin
      c_min[l] = T_SAT_NEG;
      c_max[l] = T_POS;
      for (int a = 0; a < 3; a++) begin
        if (s2_meta.zero[a]) begin
          lo = s2_t0[l][a];
          hi = s2_t1[l][a];
        end else begin
          lo = smin(s2_t0[l][a], s2_t1[l][a]);
          hi = smax(s2_t0[l][a], s2_t1[l][a]);
        end
        c_min[l] = smax(c_min[l], lo);
        c_max[l] = smin(c_max[l], hi);
      end
    end
  end

  logic          s3_vld;
  meta_t         s3_meta;
  logic [FW-1:0] s3_min [NL];
  logic [FW-1:0] s3_max [NL];
  logic [FW-1:0] s3_t0 [NL][3];
  logic [FW-1:0] s3_t1 [NL][3];

  // S3 register: entry/exit interval per lane, plus raw plane distances for the normal.
  always_ff @(posedge clk) begin
    if (reset) begin
      s3_vld <= 1'b0;
    end else if (adv) begin
      s3_vld  <= s2_vld;
      s3_meta <= s2_meta;
      s3_min  <= c_min;
      s3_max  <= c_max;
      s3_t0   <= s2_t0;
      s3_t1   <= s2_t1;
    end
  end

  logic                sel_hit;
  logic [FW-1:0]       sel_t;
  logic [PI_WIDTH-1:0] sel_pi;
  logic [LW-1:0]       sel_lane;
  logic [5:0]          sel_nrm;

  // S4 combinational: per-lane acceptance and reduction; strict compare keeps the lowest lane on ties.
  always_comb begin
    logic [FW-1:0]       ht;
    logic [PI_WIDTH-1:0] lpi;
    logic                ok;
    logic [5:0]          nrm;
    sel_hit  = 1'b0;
    sel_t    = s3_max[0];
    sel_pi   = '1;
    sel_lane = '0;
    sel_nrm  = '0;
    ht       = '0;
    lpi      = '0;
    ok       = 1'b0;
    nrm      = '0;
    for (int l = 0; l < NL; l++) begin
      ht  = is_pos(s3_min[l]) ? s3_min[l] : s3_max[l];
      lpi = s3_meta.lane_pi[l*PI_WIDTH +: PI_WIDTH];
      ok  = slt(s3_min[l], s3_max[l]) && is_pos(s3_max[l])
         && (s3_meta.max_t[FW-1] || (sle(s3_meta.min_t, ht) && sle(ht, s3_meta.max_t)))
         && !lpi[PI_WIDTH-1] && (lpi != s3_meta.ray_pi);
      for (int a = 0; a < 3; a++) begin
        if ((ht == s3_t0[l][a]) && !s3_meta.zero[a] && !s3_meta.sign[a])
          nrm[2*a +: 2] = 2'b11;
        else if ((ht == s3_t1[l][a]) && !s3_meta.zero[a] && s3_meta.sign[a])
          nrm[2*a +: 2] = 2'b01;
        else
          nrm[2*a +: 2] = 2'b00;
      end
      if (ok && (!sel_hit || (!s3_meta.mode_any && slt(ht, sel_t)))) begin
        sel_hit  = 1'b1;
        sel_t    = ht;
        sel_pi   = lpi;
        sel_lane = LW'(l);
        sel_nrm  = nrm;
      end
    end
  end

  // Output register: loads only on advance, so it holds while the consumer stalls.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid  <= 1'b0;
      out_hit    <= 1'b0;
      out_t      <= '0;
      out_pi     <= '1;
      out_lane   <= '0;
      out_normal <= '0;
    end else if (adv) begin
      out_valid <= s3_vld;
      if (s3_vld) begin
        out_hit    <= sel_hit;
        out_t      <= sel_t;
        out_pi     <= sel_pi;
        out_lane   <= sel_lane;
        out_normal <= sel_nrm;
      end
    end
  end

  // Saturating count of hits actually handed to the consumer; clear wins over increment.
  always_ff @(posedge clk) begin
    if (reset || stat_clear)
      hit_count <= '0;
    else if (out_valid && out_ready && out_hit && !(&hit_count))
      hit_count <= hit_count + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  end

endmodule
